// File: rtl/rv32_regfile_alu_unit.sv
// Execution-stage datapath slice: 32x32 register file, 32-bit ALU, funct3 one-hot decoder.
// Latency: reads, ALU and decoder are combinational; register writes land on the rising clk edge.
// Backpressure: none; every input is consumed each cycle and outputs are always valid.
//
// Ports:
//   clk, reset                     clock and synchronous active-high reset (clears registers only)
//   rf_wen, rf_waddr, rf_wdata     synchronous write port (writes to x0 are dropped)
//   rf_raddr1/rf_rdata1            combinational read port 1 (rs1)
//   rf_raddr2/rf_rdata2            combinational read port 2 (rs2)
//   alu_src1, alu_src2, alu_op     ALU operands and operation select
//   alu_result                     combinational ALU result
//   dec_in, dec_out                funct3 in, one-hot decode out

module rv32_regfile_alu_unit #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rf_wen,
  input  logic [ADDR_W-1:0] rf_waddr,
  input  logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] rf_raddr1,
  output logic [DATA_W-1:0] rf_rdata1,
  input  logic [ADDR_W-1:0] rf_raddr2,
  output logic [DATA_W-1:0] rf_rdata2,
  input  logic [DATA_W-1:0] alu_src1,
  input  logic [DATA_W-1:0] alu_src2,
  input  logic [3:0]        alu_op,
  output logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        dec_in,
  output logic [7:0]        dec_out
);

  localparam int NREG = 2 ** ADDR_W;

  // ALU operation encodings
  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_PASSB = 4'b1010;

  // ---------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------
  logic [DATA_W-1:0] regs [NREG];

  // Reset wins over a write in the same cycle. x0 is never written, so it
  // stays at its reset value; the read mux below forces 0 regardless.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (rf_wen && (rf_waddr != '0)) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // No write-to-read bypass: a read of the register being written returns
  // the pre-edge contents.
  assign rf_rdata1 = (rf_raddr1 == '0) ? '0 : regs[rf_raddr1];
  assign rf_rdata2 = (rf_raddr2 == '0) ? '0 : regs[rf_raddr2];

  // ---------------------------------------------------------------
  // ALU
  // ---------------------------------------------------------------
  logic [4:0] shamt;
  logic       lt_signed;
  logic       lt_unsigned;

  // Only the low five bits of B form the shift amount.
  assign shamt       = alu_src2[4:0];
  assign lt_signed   = $signed(alu_src1) < $signed(alu_src2);
  assign lt_unsigned = alu_src1 < alu_src2;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:   alu_result = alu_src1 + alu_src2;
      OP_SUB:   alu_result = alu_src1 - alu_src2;
      OP_AND:   alu_result = alu_src1 & alu_src2;
      OP_OR:    alu_result = alu_src1 | alu_src2;
      OP_XOR:   alu_result = alu_src1 ^ alu_src2;
      OP_SLL:   alu_result = alu_src1 << shamt;
      OP_SRL:   alu_result = alu_src1 >> shamt;
      OP_SRA:   alu_result = $unsigned($signed(alu_src1) >>> shamt);
      OP_SLT:   alu_result = {{(DATA_W-1){1'b0}}, lt_signed};
      OP_SLTU:  alu_result = {{(DATA_W-1){1'b0}}, lt_unsigned};
      OP_PASSB: alu_result = alu_src2;
      default:  alu_result = '0;
    endcase
  end

  // ---------------------------------------------------------------
  // funct3 one-hot decoder
  // ---------------------------------------------------------------
  assign dec_out = 8'b0000_0001 << dec_in;

endmodule

// File: tb/tb_rv32_regfile_alu_unit.sv
module tb_rv32_regfile_alu_unit;

  localparam int K_RD1 = 0;
  localparam int K_RD2 = 1;
  localparam int K_ALU = 2;
  localparam int K_DEC = 3;

  logic        clk;
  logic        reset;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  rf_raddr1;
  logic [31:0] rf_rdata1;
  logic [4:0]  rf_raddr2;
  logic [31:0] rf_rdata2;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [3:0]  alu_op;
  logic [31:0] alu_result;
  logic [2:0]  dec_in;
  logic [7:0]  dec_out;

  rv32_regfile_alu_unit dut (
    .clk        (clk),
    .reset      (reset),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .rf_raddr1  (rf_raddr1),
    .rf_rdata1  (rf_rdata1),
    .rf_raddr2  (rf_raddr2),
    .rf_rdata2  (rf_rdata2),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .dec_in     (dec_in),
    .dec_out    (dec_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } chk_t;

  chk_t q[$];
  logic sample_vld;
  int   errors;
  int   checks;

  // Monitor: pops one expectation whenever the stimulus marks a sample cycle,
  // and compares on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (sample_vld) begin
      chk_t        c;
      logic [31:0] act;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow: sample requested with empty queue");
      end else begin
        c = q.pop_front();
        case (c.kind)
          K_RD1:   act = rf_rdata1;
          K_RD2:   act = rf_rdata2;
          K_ALU:   act = alu_result;
          default: act = {24'h0, dec_out};
        endcase
        if (act !== c.exp) begin
          errors++;
          $display("FAIL %s: got 0x%08h expected 0x%08h", c.name, act, c.exp);
        end
      end
    end
  end

  // Push an expectation for the inputs currently applied, hold one cycle.
  task automatic expect_out(input int kind, input logic [31:0] exp, input string name);
    chk_t c;
    c.kind = kind;
    c.exp  = exp;
    c.name = name;
    q.push_back(c);
    sample_vld = 1'b1;
    @(posedge clk);
    #1;
    sample_vld = 1'b0;
  endtask

  task automatic rf_write(input logic [4:0] a, input logic [31:0] d);
    rf_wen   = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    @(posedge clk);
    #1;
    rf_wen = 1'b0;
  endtask

  task automatic alu_chk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name);
    alu_op   = op;
    alu_src1 = a;
    alu_src2 = b;
    expect_out(K_ALU, exp, name);
  endtask

  function automatic logic [31:0] pattern(input int i);
    return 32'hC0DE0000 | (32'(i) << 8) | 32'(31 - i);
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    errors     = 0;
    checks     = 0;
    sample_vld = 1'b0;
    reset      = 1'b1;
    rf_wen     = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    rf_raddr1  = '0;
    rf_raddr2  = '0;
    alu_src1   = '0;
    alu_src2   = '0;
    alu_op     = '0;
    dec_in     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // After reset every index reads 0 on both ports.
    for (int i = 0; i < 32; i++) begin
      rf_raddr1 = 5'(i);
      rf_raddr2 = 5'(31 - i);
      expect_out(K_RD1, 32'h0, $sformatf("rst_rd1_x%0d", i));
      expect_out(K_RD2, 32'h0, $sformatf("rst_rd2_x%0d", 31 - i));
    end

    // x0 ignores writes.
    rf_write(5'd0, 32'hDEADBEEF);
    rf_raddr1 = 5'd0;
    rf_raddr2 = 5'd0;
    expect_out(K_RD1, 32'h0, "x0_rd1");
    expect_out(K_RD2, 32'h0, "x0_rd2");

    // Same-cycle write/read of x5: old value before the edge, new after.
    rf_raddr1 = 5'd5;
    rf_raddr2 = 5'd5;
    rf_wen    = 1'b1;
    rf_waddr  = 5'd5;
    rf_wdata  = 32'h12345678;
    expect_out(K_RD1, 32'h0, "x5_before_edge");
    rf_wen = 1'b0;
    expect_out(K_RD1, 32'h12345678, "x5_after_rd1");
    expect_out(K_RD2, 32'h12345678, "x5_after_rd2");

    // Distinct pattern in every register, read back through both ports.
    for (int i = 1; i < 32; i++) rf_write(5'(i), pattern(i));
    for (int i = 1; i < 32; i++) begin
      rf_raddr1 = 5'(i);
      rf_raddr2 = 5'(32 - i);
      expect_out(K_RD1, pattern(i), $sformatf("pat_rd1_x%0d", i));
      expect_out(K_RD2, pattern(32 - i), $sformatf("pat_rd2_x%0d", 32 - i));
    end

    // Reset wins over a simultaneous write.
    rf_write(5'd3, 32'hAAAA5555);
    rf_raddr1 = 5'd3;
    expect_out(K_RD1, 32'hAAAA5555, "x3_pre_reset");
    reset    = 1'b1;
    rf_wen   = 1'b1;
    rf_waddr = 5'd3;
    rf_wdata = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    reset  = 1'b0;
    rf_wen = 1'b0;
    expect_out(K_RD1, 32'h0, "x3_reset_priority");
    rf_raddr2 = 5'd17;
    expect_out(K_RD2, 32'h0, "x17_cleared");

    // ALU
    alu_chk(4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "add_wrap");
    alu_chk(4'b0000, 32'h12345678, 32'h11111111, 32'h23456789, "add");
    alu_chk(4'b0001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, "sub_wrap");
    alu_chk(4'b0001, 32'h00000010, 32'h00000003, 32'h0000000D, "sub");
    alu_chk(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
    alu_chk(4'b0011, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, "or");
    alu_chk(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
    alu_chk(4'b0101, 32'h80000010, 32'h00000024, 32'h00000100, "sll");
    alu_chk(4'b0110, 32'h80000010, 32'h00000004, 32'h08000001, "srl");
    alu_chk(4'b0111, 32'h80000010, 32'h00000004, 32'hF8000001, "sra_neg");
    alu_chk(4'b0111, 32'h40000000, 32'hFFFFFFE4, 32'h04000000, "sra_pos");
    alu_chk(4'b1000, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, "slt_true");
    alu_chk(4'b1000, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, "slt_false");
    alu_chk(4'b1001, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, "sltu_false");
    alu_chk(4'b1001, 32'h00000001, 32'hFFFFFFFF, 32'h00000001, "sltu_true");
    alu_chk(4'b1010, 32'h12345678, 32'h80000000, 32'h80000000, "passb");
    alu_chk(4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "op1011");
    alu_chk(4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, "op1111");

    // Decoder sweep
    dec_in = 3'd0; expect_out(K_DEC, 32'h01, "dec0");
    dec_in = 3'd1; expect_out(K_DEC, 32'h02, "dec1");
    dec_in = 3'd2; expect_out(K_DEC, 32'h04, "dec2");
    dec_in = 3'd3; expect_out(K_DEC, 32'h08, "dec3");
    dec_in = 3'd4; expect_out(K_DEC, 32'h10, "dec4");
    dec_in = 3'd5; expect_out(K_DEC, 32'h20, "dec5");
    dec_in = 3'd6; expect_out(K_DEC, 32'h40, "dec6");
    dec_in = 3'd7; expect_out(K_DEC, 32'h80, "dec7");

    repeat (2) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
